// File: rtl/net_share_arbiter.sv
// Round-robin owner scheduler for one shared DW-bit net.
// Grants one requester at a time, limits hold time, and inserts one turnaround cycle.
module net_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DW       = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    rel,
  input  logic [N_REQ*DW-1:0] din,
  output logic [N_REQ-1:0]    gnt,
  output logic [DW-1:0]       dd,
  output logic                dd_vld,
  output logic                busy,
  output logic                timeout
);

  localparam int OW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t           state, state_n;
  logic [OW-1:0]    owner, owner_n;
  logic [OW-1:0]    last_owner, last_owner_n;
  logic [HW-1:0]    hold_cnt, hold_cnt_n;
  logic [N_REQ-1:0] gnt_n;
  logic [DW-1:0]    dd_n;
  logic             dd_vld_n;
  logic             timeout_n;
  logic [DW-1:0]    din_arr [N_REQ];
  logic [OW-1:0]    sel;
  logic [OW-1:0]    idx;
  int               idx_full;
  logic             found;
  logic             at_limit;
  logic             exit_own;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) din_arr[i] = din[i*DW +: DW];
  end

  // Scan starts just after the previous owner, so whoever last held the net is considered last.
  always_comb begin
    sel      = '0;
    found    = 1'b0;
    idx      = '0;
    idx_full = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx_full = (int'(last_owner) + i) % N_REQ;
      idx      = OW'(idx_full);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign at_limit = (hold_cnt == HW'(MAX_HOLD - 1));
  assign exit_own = rel[owner] || !req[owner] || at_limit;
  assign busy     = (state != IDLE);

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    hold_cnt_n   = hold_cnt;
    gnt_n        = gnt;
    dd_n         = dd;
    dd_vld_n     = 1'b0;
    timeout_n    = 1'b0;
    case (state)
      IDLE: begin
        gnt_n = '0;
        if (found) begin
          gnt_n[sel] = 1'b1;
          owner_n    = sel;
          hold_cnt_n = '0;
          state_n    = OWN;
        end
      end
      OWN: begin
        if (exit_own) begin
          // A release or request drop on the limit edge is a normal exit, not a timeout.
          gnt_n        = '0;
          last_owner_n = owner;
          timeout_n    = at_limit && !rel[owner] && req[owner];
          state_n      = GAP;
        end else begin
          dd_n       = din_arr[owner];
          dd_vld_n   = 1'b1;
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end
      GAP: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(N_REQ - 1);
      hold_cnt   <= '0;
      gnt        <= '0;
      dd         <= '0;
      dd_vld     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_owner_n;
      hold_cnt   <= hold_cnt_n;
      gnt        <= gnt_n;
      dd         <= dd_n;
      dd_vld     <= dd_vld_n;
      timeout    <= timeout_n;
    end
  end

endmodule

// File: tb/tb_net_share_arbiter.sv
// Directed bench for net_share_arbiter: reset, release, round robin, wrap, limit races, mid-grant reset.
// Outputs are sampled 1ns after each rising edge; inputs change at that time too.
module tb_net_share_arbiter;

  localparam int N_REQ    = 4;
  localparam int DW       = 16;
  localparam int MAX_HOLD = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    rel;
  logic [N_REQ*DW-1:0] din;
  logic [N_REQ-1:0]    gnt;
  logic [DW-1:0]       dd;
  logic                dd_vld;
  logic                busy;
  logic                timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] din_val [N_REQ];
  logic [DW-1:0] exp_dd;

  always #5 clk = ~clk;

  net_share_arbiter #(.N_REQ(N_REQ), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .din(din),
    .gnt(gnt), .dd(dd), .dd_vld(dd_vld), .busy(busy), .timeout(timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic r, input logic [N_REQ-1:0] q, input logic [N_REQ-1:0] l);
    rst = r;
    req = q;
    rel = l;
  endtask

  task automatic check_one(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_output(input string tag, input logic [N_REQ-1:0] e_gnt, input logic [DW-1:0] e_dd,
                              input logic e_vld, input logic e_busy, input logic e_to);
    check_one({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    check_one({tag, ".dd"}, 32'(dd), 32'(e_dd));
    check_one({tag, ".dd_vld"}, 32'(dd_vld), 32'(e_vld));
    check_one({tag, ".busy"}, 32'(busy), 32'(e_busy));
    check_one({tag, ".timeout"}, 32'(timeout), 32'(e_to));
  endtask

  initial begin
    din_val[0] = 16'h1111;
    din_val[1] = 16'h2222;
    din_val[2] = 16'hA5A5;
    din_val[3] = 16'h4444;
    din = {din_val[3], din_val[2], din_val[1], din_val[0]};

    apply_stimulus(1'b1, 4'b0000, 4'b0000);
    step();
    step();
    check_output("reset", 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Single requester 2, non-owner rel ignored, release on third OWN cycle.
    apply_stimulus(1'b0, 4'b0100, 4'b0000);
    step();
    check_output("single_gnt", 4'b0100, 16'h0000, 1'b0, 1'b1, 1'b0);
    step();
    check_output("single_dd", 4'b0100, 16'hA5A5, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b0, 4'b0100, 4'b1011);
    step();
    check_output("nonowner_rel", 4'b0100, 16'hA5A5, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b0, 4'b0100, 4'b0100);
    step();
    check_output("release", 4'b0000, 16'hA5A5, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 4'b0000);
    step();
    check_output("gap_to_idle", 4'b0000, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    step();
    check_output("idle_hold", 4'b0000, 16'hA5A5, 1'b0, 1'b0, 1'b0);

    // Round robin with all requesters held: owners 0,1,2,3,0 each revoked by hold limit.
    apply_stimulus(1'b1, 4'b0000, 4'b0000);
    step();
    check_output("reset2", 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    exp_dd = 16'h0000;
    apply_stimulus(1'b0, 4'b1111, 4'b0000);
    for (int g = 0; g < 5; g++) begin
      int o;
      logic [N_REQ-1:0] oh;
      o  = g % N_REQ;
      oh = N_REQ'(1 << o);
      step();
      check_output("rr_grant", oh, exp_dd, 1'b0, 1'b1, 1'b0);
      exp_dd = din_val[o];
      for (int c = 0; c < MAX_HOLD - 1; c++) begin
        step();
        check_output("rr_own", oh, exp_dd, 1'b1, 1'b1, 1'b0);
      end
      step();
      check_output("rr_timeout", 4'b0000, exp_dd, 1'b0, 1'b1, 1'b1);
      step();
      check_output("rr_gap", 4'b0000, exp_dd, 1'b0, 1'b0, 1'b0);
    end

    // Grant 3, drop its req to exit, then wrap to requester 0.
    apply_stimulus(1'b0, 4'b1000, 4'b0000);
    step();
    check_output("grant3", 4'b1000, 16'h1111, 1'b0, 1'b1, 1'b0);
    step();
    check_output("own3", 4'b1000, 16'h4444, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b0, 4'b0001, 4'b0000);
    step();
    check_output("req_drop", 4'b0000, 16'h4444, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 4'b1001, 4'b0000);
    step();
    check_output("gap3", 4'b0000, 16'h4444, 1'b0, 1'b0, 1'b0);
    step();
    check_output("wrap_gnt", 4'b0001, 16'h4444, 1'b0, 1'b1, 1'b0);

    // Non-owner req drop has no effect; rel coincides with the hold limit.
    apply_stimulus(1'b0, 4'b0001, 4'b0000);
    for (int c = 0; c < MAX_HOLD - 1; c++) begin
      step();
      check_output("own0", 4'b0001, 16'h1111, 1'b1, 1'b1, 1'b0);
    end
    apply_stimulus(1'b0, 4'b0001, 4'b0001);
    step();
    check_output("rel_at_limit", 4'b0000, 16'h1111, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 4'b0000);
    step();
    check_output("gap0", 4'b0000, 16'h1111, 1'b0, 1'b0, 1'b0);

    // Reset during requester 1's grant, then requester 0 wins first.
    apply_stimulus(1'b0, 4'b0010, 4'b0000);
    step();
    check_output("grant1", 4'b0010, 16'h1111, 1'b0, 1'b1, 1'b0);
    step();
    check_output("own1", 4'b0010, 16'h2222, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 4'b0011, 4'b0000);
    step();
    check_output("mid_reset", 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'b0011, 4'b0000);
    step();
    check_output("post_reset_gnt", 4'b0001, 16'h0000, 1'b0, 1'b1, 1'b0);
    step();
    check_output("post_reset_dd", 4'b0001, 16'h1111, 1'b1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
